// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - first-word-fall-through instruction buffer between fetch and dispatch
// Circular buffer of {instruction, PC} pairs with single-cycle flush, almost-full stall and sticky overflow.
module inst_fetch_queue #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDRESS_WIDTH = 32,
  parameter int                    DEPTH         = 8,
  parameter int                    AFULL_THRESH  = 6,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD      = 'h00000013
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       wr_en_i,
  input  logic [DATA_WIDTH-1:0]      wr_instruction_i,
  input  logic [ADDRESS_WIDTH-1:0]   wr_pc_i,
  input  logic                       flush_i,
  input  logic                       rd_en_i,
  output logic                       rd_valid_o,
  output logic [DATA_WIDTH-1:0]      rd_instruction_o,
  output logic [ADDRESS_WIDTH-1:0]   rd_pc_o,
  output logic                       full_o,
  output logic                       almost_full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic write_ok;
  logic read_ok;

  // Flags come from the registered count only, so full is judged before any same-cycle read.
  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign almost_full_o = (count_q >= CNT_W'(AFULL_THRESH));
  assign rd_valid_o    = !empty_o;
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;

  assign write_ok = wr_en_i && !full_o  && !flush_i;
  assign read_ok  = rd_en_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (write_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (read_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({write_ok, read_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (wr_en_i && full_o) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the empty mux below hides stale contents.
  always_ff @(posedge clk_i) begin
    if (!reset_i && write_ok) begin
      instr_mem[wr_ptr_q] <= wr_instruction_i;
      pc_mem[wr_ptr_q]    <= wr_pc_i;
    end
  end

  assign rd_instruction_o = empty_o ? NOP_WORD : instr_mem[rd_ptr_q];
  assign rd_pc_o          = empty_o ? '0       : pc_mem[rd_ptr_q];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed bench with queue-based reference model for inst_fetch_queue
module tb_inst_fetch_queue;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_instruction = '0;
  logic [AW-1:0] wr_pc = '0;
  logic          flush = 1'b0;
  logic          rd_en = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_instruction;
  logic [AW-1:0] rd_pc;
  logic          full;
  logic          almost_full;
  logic          empty;
  logic [3:0]    count;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  bit compare_on = 1'b0;

  logic [63:0] model_q [$];
  bit          model_ovf = 1'b0;

  inst_fetch_queue #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .AFULL_THRESH(AFT), .NOP_WORD(NOP)
  ) dut (
    .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_instruction_i(wr_instruction),
    .wr_pc_i(wr_pc), .flush_i(flush), .rd_en_i(rd_en), .rd_valid_o(rd_valid),
    .rd_instruction_o(rd_instruction), .rd_pc_o(rd_pc), .full_o(full),
    .almost_full_o(almost_full), .empty_o(empty), .count_o(count), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input int n);
    return (32'(n) << 20) | (32'(n & 31) << 7) | 32'h13;
  endfunction

  // Reference model: a plain FIFO queue plus the acceptance rules.
  always @(posedge clk) begin
    if (reset) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else if (flush) begin
      model_q.delete();
    end else begin
      automatic bit was_full  = (model_q.size() == DEPTH);
      automatic bit was_empty = (model_q.size() == 0);
      if (wr_en && was_full) model_ovf = 1'b1;
      if (rd_en && !was_empty) void'(model_q.pop_front());
      if (wr_en && !was_full) model_q.push_back({wr_instruction, wr_pc});
    end
  end

  always @(negedge clk) begin
    if (compare_on) begin
      automatic int n = model_q.size();
      check("cyc_count",    32'(count),          32'(n));
      check("cyc_empty",    32'(empty),          32'(n == 0));
      check("cyc_full",     32'(full),           32'(n == DEPTH));
      check("cyc_afull",    32'(almost_full),    32'(n >= AFT));
      check("cyc_valid",    32'(rd_valid),       32'(n != 0));
      check("cyc_overflow", 32'(overflow),       32'(model_ovf));
      check("cyc_instr",    rd_instruction,      (n != 0) ? model_q[0][63:32] : NOP);
      check("cyc_pc",       rd_pc,               (n != 0) ? model_q[0][31:0]  : 32'h0);
    end
  end

  task automatic step(input bit w, input logic [31:0] ins, input logic [31:0] pc,
                      input bit r, input bit f, input bit rst);
    wr_en = w; wr_instruction = ins; wr_pc = pc; rd_en = r; flush = f; reset = rst;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    compare_on = 1'b1;
    check("rst_empty", 32'(empty), 1);
    check("rst_count", 32'(count), 0);
    check("rst_instr", rd_instruction, NOP);
    check("rst_pc", rd_pc, 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_full", 32'(full), 0);

    step(1, instr_of(1), 32'h0, 0, 0, 0);
    check("w1_instr", rd_instruction, 32'h00100093);
    check("w1_pc", rd_pc, 32'h0);
    check("w1_empty", 32'(empty), 0);
    step(1, instr_of(2), 32'h4, 0, 0, 0);
    step(1, instr_of(3), 32'h8, 0, 0, 0);
    check("w3_count", 32'(count), 3);
    check("model_pin_size3", 32'(model_q.size()), 3);
    check("model_pin_instr3", model_q[2][63:32], 32'h00300193);

    for (int i = 3; i < 8; i++) begin
      step(1, instr_of(i + 1), 32'(4 * i), 0, 0, 0);
      if (i == 4) check("af_at5", 32'(almost_full), 0);
      if (i == 5) check("af_at6", 32'(almost_full), 1);
    end
    check("fill_full", 32'(full), 1);
    check("fill_ovf_pre", 32'(overflow), 0);
    step(1, instr_of(9), 32'h20, 0, 0, 0);
    check("ovf_count", 32'(count), 8);
    check("ovf_set", 32'(overflow), 1);

    for (int i = 0; i < 8; i++) begin
      check("drain_pc", rd_pc, 32'(4 * i));
      step(0, 0, 0, 1, 0, 0);
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_nop", rd_instruction, 32'h00000013);

    for (int i = 0; i < 4; i++) step(1, instr_of(16 + i), 32'h40 + 32'(4 * i), 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      check("stream_pc", rd_pc, 32'h40 + 32'(4 * k));
      step(1, instr_of(20 + k), 32'h50 + 32'(4 * k), 1, 0, 0);
      check("stream_count", 32'(count), 4);
    end

    step(1, instr_of(50), 32'h200, 0, 0, 0);
    check("pre_flush_count", 32'(count), 5);
    step(1, instr_of(51), 32'h204, 1, 1, 0);
    check("flush_count", 32'(count), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_pc", rd_pc, 0);
    check("flush_ovf_kept", 32'(overflow), 1);
    step(1, instr_of(52), 32'h100, 0, 0, 0);
    check("post_flush_pc", rd_pc, 32'h100);

    for (int i = 0; i < 5; i++) step(1, instr_of(60 + i), 32'h300 + 32'(4 * i), 0, 0, 0);
    check("af_rise", 32'(almost_full), 1);
    step(0, 0, 0, 1, 0, 0);
    check("af_fall_count", 32'(count), 5);
    check("af_fall", 32'(almost_full), 0);

    for (int i = 0; i < 3; i++) step(1, instr_of(70 + i), 32'h400 + 32'(4 * i), 0, 0, 0);
    check("full_again", 32'(full), 1);
    step(1, instr_of(80), 32'h500, 1, 0, 0);
    check("full_wr_rd_count", 32'(count), 7);

    step(1, instr_of(81), 32'h600, 0, 0, 1);
    check("rst_mid_count", 32'(count), 0);
    check("rst_mid_empty", 32'(empty), 1);
    check("rst_mid_ovf", 32'(overflow), 0);

    step(0, 0, 0, 1, 0, 0);
    check("rd_empty_ignored", 32'(count), 0);
    step(1, instr_of(90), 32'h700, 1, 0, 0);
    check("empty_wr_rd_count", 32'(count), 1);
    check("empty_wr_rd_pc", rd_pc, 32'h700);

    @(negedge clk);
    compare_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
